// File: rtl/lif_pkg.sv
// Shared sizing constants and types for the time-multiplexed LIF scheduler.
package lif_pkg;

  localparam int unsigned N              = 8;
  localparam int unsigned W              = 8;
  localparam int unsigned THRESH_DEFAULT = 200;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    COMMIT
  } fsm_t;

  typedef logic [$clog2(N)-1:0] slot_t;

endpackage

// File: rtl/lif_tdm_scheduler_if.sv
// Control/observation bundle between the pin-side driver and the LIF scheduler.
interface lif_tdm_scheduler_if;
  import lif_pkg::*;

  logic         en;
  logic [W-1:0] current;
  logic         cfg_we;
  slot_t        cfg_addr;
  logic [W-1:0] cfg_data;
  slot_t        slot;
  logic         busy;
  logic [W-1:0] state;
  logic [N-1:0] spike;
  logic         frame_done;

  modport master (
    output en, current, cfg_we, cfg_addr, cfg_data,
    input  slot, busy, state, spike, frame_done
  );

  modport slave (
    input  en, current, cfg_we, cfg_addr, cfg_data,
    output slot, busy, state, spike, frame_done
  );

endinterface

// File: rtl/lif_update.sv
// Combinational leaky-integrate-and-fire step for one neuron: leak by half,
// add current (suppressed while refractory), saturate, compare to threshold.
module lif_update
  import lif_pkg::*;
(
  input  logic [W-1:0] mem,
  input  logic [W-1:0] current,
  input  logic [W-1:0] thr,
  input  logic [1:0]   refr,
  output logic [W-1:0] next,
  output logic         fire
);

  logic [W-1:0] eff;
  logic [W:0]   sum;

  always_comb begin
    eff  = (refr != 2'd0) ? '0 : current;
    sum  = {1'b0, eff} + {2'b00, mem[W-1:1]};
    next = sum[W] ? '1 : sum[W-1:0];
    fire = (refr == 2'd0) && (next >= thr);
  end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// Round-robin scheduler sharing one lif_update across N virtual neurons,
// two cycles per neuron (CALC, COMMIT), publishing a spike vector per frame.
module lif_tdm_scheduler
  import lif_pkg::*;
#(
  parameter int unsigned REFRAC = 2
) (
  input logic               clk,
  input logic               rst_n,
  lif_tdm_scheduler_if.slave bus
);

  fsm_t         fsm_q, fsm_d;
  slot_t        slot_q, slot_d;

  logic [W-1:0] mem  [N];
  logic [W-1:0] thr  [N];
  logic [1:0]   refr [N];

  logic [W-1:0] upd_next, next_q;
  logic         upd_fire, fire_q;
  logic [N-1:0] shadow_q, shadow_set, spike_q;
  logic         frame_done_q;
  logic         last_commit;

  lif_update u_update (
    .mem     (mem[slot_q]),
    .current (bus.current),
    .thr     (thr[slot_q]),
    .refr    (refr[slot_q]),
    .next    (upd_next),
    .fire    (upd_fire)
  );

  assign last_commit = (fsm_q == COMMIT) && (slot_q == slot_t'(N - 1));

  always_comb begin
    fsm_d  = fsm_q;
    slot_d = slot_q;
    case (fsm_q)
      IDLE: begin
        if (bus.en) begin
          fsm_d  = CALC;
          slot_d = '0;
        end
      end
      CALC: fsm_d = COMMIT;
      COMMIT: begin
        if (last_commit) begin
          // Slot only moves on entry to CALC; IDLE keeps the last slot shown.
          if (bus.en) begin
            fsm_d  = CALC;
            slot_d = '0;
          end else begin
            fsm_d = IDLE;
          end
        end else begin
          fsm_d  = CALC;
          slot_d = slot_q + slot_t'(1);
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      slot_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      slot_q <= slot_d;
    end
  end

  // Threshold writes land on the clock edge, so a concurrent CALC sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr <= '{default: W'(THRESH_DEFAULT)};
    end else if (bus.cfg_we) begin
      thr[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_comb begin
    shadow_set         = shadow_q;
    shadow_set[slot_q] = fire_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem          <= '{default: '0};
      refr         <= '{default: '0};
      next_q       <= '0;
      fire_q       <= 1'b0;
      shadow_q     <= '0;
      spike_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_commit;
      if (fsm_q == CALC) begin
        next_q <= upd_next;
        fire_q <= upd_fire;
      end
      if (fsm_q == COMMIT) begin
        if (fire_q) begin
          mem[slot_q]  <= '0;
          refr[slot_q] <= 2'(REFRAC);
        end else begin
          mem[slot_q] <= next_q;
          if (refr[slot_q] != 2'd0) refr[slot_q] <= refr[slot_q] - 2'd1;
        end
        if (last_commit) begin
          spike_q  <= shadow_set;
          shadow_q <= '0;
        end else begin
          shadow_q <= shadow_set;
        end
      end
    end
  end

  assign bus.slot       = slot_q;
  assign bus.busy       = (fsm_q != IDLE);
  assign bus.state      = next_q;
  assign bus.spike      = spike_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Directed + randomized bench for lif_tdm_scheduler against a per-neuron integer model.
module tb_lif_tdm_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  lif_tdm_scheduler_if bus ();

  lif_tdm_scheduler #(.REFRAC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         mem_m  [8];
  int         thr_m  [8];
  int         refr_m [8];
  logic [7:0] shadow_m;
  logic [7:0] spike_m;
  int         cur_tab [8];
  logic [7:0] obs_state [8];
  logic [7:0] last_spike;

  int exp_m0  [8] = '{120, 180, 210, 0, 0, 120, 180, 210};
  int exp_sp0 [8] = '{0, 0, 1, 0, 0, 0, 0, 1};
  int exp_sp3 [4] = '{1, 0, 0, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mem_m[i]  = 0;
      thr_m[i]  = 200;
      refr_m[i] = 0;
    end
    shadow_m = '0;
    spike_m  = '0;
  endtask

  // Starts at the negedge inside CALC of slot 0; ends at the negedge after slot 7 COMMIT.
  task automatic run_frame(input int cfg_k, input int cfg_a, input int cfg_d, input int drop_k);
    int nxt;
    int eff;
    int i;
    bit fire;
    int exp_state;
    exp_state = 0;
    for (int k = 0; k < 16; k++) begin
      i = k / 2;
      check("busy_in_frame", {31'b0, bus.busy}, 1);
      check("slot", {29'b0, bus.slot}, i);
      if (k > 0) check("frame_done_low", {31'b0, bus.frame_done}, 0);
      if (k % 2 == 0) begin
        bus.current = 8'(cur_tab[i]);
        eff  = (refr_m[i] != 0) ? 0 : cur_tab[i];
        nxt  = eff + mem_m[i] / 2;
        if (nxt > 255) nxt = 255;
        fire = (refr_m[i] == 0) && (nxt >= thr_m[i]);
        exp_state = nxt;
        if (fire) begin
          mem_m[i]  = 0;
          refr_m[i] = 2;
        end else begin
          mem_m[i] = nxt;
          if (refr_m[i] > 0) refr_m[i]--;
        end
        shadow_m[i] = fire;
      end else begin
        check("state", {24'b0, bus.state}, exp_state);
        obs_state[i] = bus.state;
      end
      if (k == cfg_k) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'(cfg_a);
        bus.cfg_data = 8'(cfg_d);
        thr_m[cfg_a] = cfg_d;
      end else begin
        bus.cfg_we = 1'b0;
      end
      if (k == drop_k) bus.en = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    bus.cfg_we = 1'b0;
    check("frame_done_pulse", {31'b0, bus.frame_done}, 1);
    check("spike", {24'b0, bus.spike}, {24'b0, shadow_m});
    last_spike = bus.spike;
    spike_m    = shadow_m;
    shadow_m   = '0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.current  = '0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    model_reset();
    for (int i = 0; i < 8; i++) cur_tab[i] = 0;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_slot", {29'b0, bus.slot}, 0);
    check("rst_spike", {24'b0, bus.spike}, 0);
    check("rst_frame_done", {31'b0, bus.frame_done}, 0);
    check("rst_state", {24'b0, bus.state}, 0);

    // Partial frame with random drive, then reset mid-frame.
    rst_n  = 1'b1;
    bus.en = 1'b1;
    repeat (9) begin
      bus.current = 8'($urandom_range(0, 255));
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_busy", {31'b0, bus.busy}, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, bus.busy}, 0);
    check("midrst_slot", {29'b0, bus.slot}, 0);
    check("midrst_spike", {24'b0, bus.spike}, 0);
    check("midrst_frame_done", {31'b0, bus.frame_done}, 0);
    check("midrst_state", {24'b0, bus.state}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // First frame after reset, zero current.
    run_frame(-1, 0, 0, -1);
    check("zero_frame_spike", {24'b0, last_spike}, 0);

    // Integration and refractory on neuron 0.
    cur_tab[0] = 120;
    for (int f = 0; f < 8; f++) begin
      run_frame(-1, 0, 0, -1);
      check("int_state0", {24'b0, obs_state[0]}, exp_m0[f]);
      check("int_spike0", {31'b0, last_spike[0]}, exp_sp0[f]);
    end

    // Saturation on neuron 3 with threshold 255; neuron 2 kept silent.
    for (int i = 0; i < 8; i++) cur_tab[i] = $urandom_range(0, 255);
    cur_tab[2] = 0;
    cur_tab[3] = 255;
    for (int f = 0; f < 4; f++) begin
      run_frame((f == 0) ? 0 : -1, 3, 255, -1);
      check("sat_spike3", {31'b0, last_spike[3]}, exp_sp3[f]);
      if (f == 0 || f == 3) check("sat_state3", {24'b0, obs_state[3]}, 255);
    end

    // Threshold write racing neuron 2's CALC.
    cur_tab[2] = 10;
    run_frame(4, 2, 10, -1);
    check("race_old_thr", {31'b0, last_spike[2]}, 0);
    run_frame(-1, 0, 0, -1);
    check("race_new_thr", {31'b0, last_spike[2]}, 1);

    // Enable dropped at slot 4.
    run_frame(-1, 0, 0, 8);
    check("drop_busy", {31'b0, bus.busy}, 0);
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", {31'b0, bus.busy}, 0);
      check("idle_frame_done", {31'b0, bus.frame_done}, 0);
      check("idle_spike_hold", {24'b0, bus.spike}, {24'b0, spike_m});
    end
    bus.en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run_frame(-1, 0, 0, -1);

    // Randomized frames with random threshold writes, including threshold 0.
    for (int f = 0; f < 10; f++) begin
      int ck;
      int ca;
      int cd;
      for (int i = 0; i < 8; i++) cur_tab[i] = $urandom_range(0, 255);
      ck = $urandom_range(0, 15);
      ca = $urandom_range(0, 7);
      cd = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
      run_frame(ck, ca, cd, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
